// File: rtl/ysyx_25030093_dmem_ctrl.sv
// Multi-cycle data-memory controller between the LSU and a fixed-latency,
// byte-strobed SRAM port; one request in flight, aligned/extended load data.
module ysyx_25030093_dmem_ctrl #(
  parameter int unsigned LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_func,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_en,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_e;

  state_e      state_q;
  logic [3:0]  func_q;
  logic [1:0]  off_q;
  logic [3:0]  cnt_q;
  logic        req_ready_q;
  logic        resp_valid_q;
  logic        resp_err_q;
  logic [31:0] resp_rdata_q;
  logic        mem_en_q;
  logic        mem_wen_q;
  logic [31:0] mem_addr_q;
  logic [3:0]  mem_wstrb_q;
  logic [31:0] mem_wdata_q;

  logic        req_err_d;
  logic        req_store_d;
  logic [3:0]  wstrb_d;
  logic [31:0] wdata_d;
  logic [31:0] rdata_d;
  logic [7:0]  byte_d;
  logic [15:0] half_d;

  always_comb begin
    req_store_d = (req_func == 4'd5) || (req_func == 4'd6) || (req_func == 4'd7);
    req_err_d   = req_func[3]
                | (((req_func == 4'd1) || (req_func == 4'd4) || (req_func == 4'd6)) && req_addr[0])
                | (((req_func == 4'd2) || (req_func == 4'd7)) && (req_addr[1:0] != 2'b00));
    wstrb_d = 4'b0000;
    wdata_d = 32'h0;
    case (req_func)
      4'd5: begin
        wstrb_d = 4'b0001 << req_addr[1:0];
        wdata_d = {4{req_wdata[7:0]}};
      end
      4'd6: begin
        wstrb_d = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{req_wdata[15:0]}};
      end
      4'd7: begin
        wstrb_d = 4'b1111;
        wdata_d = req_wdata;
      end
      default: ;
    endcase

    // Lane select uses the latched offset; the word itself arrives late.
    byte_d = 8'(mem_rdata >> {off_q, 3'b000});
    half_d = 16'(mem_rdata >> {off_q[1], 4'b0000});
    case (func_q)
      4'd0:    rdata_d = {{24{byte_d[7]}}, byte_d};
      4'd1:    rdata_d = {{16{half_d[15]}}, half_d};
      4'd2:    rdata_d = mem_rdata;
      4'd3:    rdata_d = {24'h0, byte_d};
      4'd4:    rdata_d = {16'h0, half_d};
      default: rdata_d = 32'h0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      func_q       <= 4'h0;
      off_q        <= 2'b00;
      cnt_q        <= 4'h0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
      mem_en_q     <= 1'b0;
      mem_wen_q    <= 1'b0;
      mem_addr_q   <= 32'h0;
      mem_wstrb_q  <= 4'h0;
      mem_wdata_q  <= 32'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            func_q      <= req_func;
            off_q       <= req_addr[1:0];
            req_ready_q <= 1'b0;
            if (req_err_d) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= 32'h0;
            end else begin
              state_q     <= ACCESS;
              mem_en_q    <= 1'b1;
              mem_wen_q   <= req_store_d;
              mem_addr_q  <= {req_addr[31:2], 2'b00};
              mem_wstrb_q <= wstrb_d;
              mem_wdata_q <= wdata_d;
            end
          end
        end
        ACCESS: begin
          state_q     <= WAIT;
          cnt_q       <= 4'(LATENCY);
          mem_en_q    <= 1'b0;
          mem_wen_q   <= 1'b0;
          mem_addr_q  <= 32'h0;
          mem_wstrb_q <= 4'h0;
          mem_wdata_q <= 32'h0;
        end
        WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q      <= RESP;
            cnt_q        <= 4'h0;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= rdata_d;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'h0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_en     = mem_en_q;
  assign mem_wen    = mem_wen_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wstrb  = mem_wstrb_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_ysyx_25030093_dmem_ctrl.sv
// Bench for ysyx_25030093_dmem_ctrl: two instances (LATENCY 1 and 4) driven
// with directed and random requests, checked against a byte-level model.
module tb_ysyx_25030093_dmem_ctrl;
  localparam int LAT0 = 1;
  localparam int LAT1 = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req_valid  [2];
  logic        req_ready  [2];
  logic [31:0] req_addr   [2];
  logic [3:0]  req_func   [2];
  logic [31:0] req_wdata  [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err   [2];
  logic        mem_en     [2];
  logic        mem_wen    [2];
  logic [31:0] mem_addr   [2];
  logic [3:0]  mem_wstrb  [2];
  logic [31:0] mem_wdata  [2];
  logic [31:0] mem_rdata  [2];

  int total = 0;
  int bad   = 0;

  ysyx_25030093_dmem_ctrl #(.LATENCY(LAT0)) u_dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
    .req_func(req_func[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]),
    .mem_en(mem_en[0]), .mem_wen(mem_wen[0]), .mem_addr(mem_addr[0]),
    .mem_wstrb(mem_wstrb[0]), .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0])
  );

  ysyx_25030093_dmem_ctrl #(.LATENCY(LAT1)) u_dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
    .req_func(req_func[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]),
    .mem_en(mem_en[1]), .mem_wen(mem_wen[1]), .mem_addr(mem_addr[1]),
    .mem_wstrb(mem_wstrb[1]), .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1])
  );

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
    logic        wen;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } exp_t;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: treat the word as four bytes and the access as (offset, size).
  function automatic exp_t model(input logic [3:0] func, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] word);
    exp_t e;
    int size;
    int off;
    bit store;
    bit sgn;
    logic [31:0] v;
    e = '0;
    off = int'(addr[1:0]);
    store = 1'b0;
    sgn = 1'b0;
    case (func)
      4'd0: begin size = 1; sgn = 1'b1; end
      4'd1: begin size = 2; sgn = 1'b1; end
      4'd2: size = 4;
      4'd3: size = 1;
      4'd4: size = 2;
      4'd5: begin size = 1; store = 1'b1; end
      4'd6: begin size = 2; store = 1'b1; end
      4'd7: begin size = 4; store = 1'b1; end
      default: size = 0;
    endcase
    if (size == 0 || (off % size) != 0) begin
      e.err = 1'b1;
      return e;
    end
    if (store) begin
      e.wen = 1'b1;
      for (int i = 0; i < 4; i++) begin
        e.wstrb[i] = (i >= off) && (i < off + size);
        e.wdata[8*i +: 8] = wdata[8*(i % size) +: 8];
      end
    end else begin
      v = 32'h0;
      for (int i = 0; i < size; i++) v = v | (32'(word[8*(off+i) +: 8]) << (8*i));
      if (sgn && size < 4 && v[8*size-1]) v = v | ~((32'd1 << (8*size)) - 32'd1);
      e.rdata = v;
    end
    return e;
  endfunction

  task automatic check_reset_vals(input int k, input string tag);
    check($sformatf("%s.req_ready%0d", tag, k), 32'(req_ready[k]), 32'd1);
    check($sformatf("%s.resp_valid%0d", tag, k), 32'(resp_valid[k]), 32'd0);
    check($sformatf("%s.resp_rdata%0d", tag, k), resp_rdata[k], 32'd0);
    check($sformatf("%s.resp_err%0d", tag, k), 32'(resp_err[k]), 32'd0);
    check($sformatf("%s.mem_en%0d", tag, k), 32'(mem_en[k]), 32'd0);
    check($sformatf("%s.mem_wen%0d", tag, k), 32'(mem_wen[k]), 32'd0);
    check($sformatf("%s.mem_wstrb%0d", tag, k), 32'(mem_wstrb[k]), 32'd0);
    check($sformatf("%s.mem_addr%0d", tag, k), mem_addr[k], 32'd0);
    check($sformatf("%s.mem_wdata%0d", tag, k), mem_wdata[k], 32'd0);
  endtask

  // Called at a negedge with instance k idle; returns at a negedge with it idle.
  task automatic txn(input int k, input logic [3:0] func, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] word,
                     input int hold, input bit pulse);
    int lat;
    exp_t e;
    lat = (k == 0) ? LAT0 : LAT1;
    e = model(func, addr, wdata, word);
    check("idle.req_ready", 32'(req_ready[k]), 32'd1);
    req_valid[k] = 1'b1;
    req_func[k]  = func;
    req_addr[k]  = addr;
    req_wdata[k] = wdata;
    mem_rdata[k] = $urandom;
    @(negedge clk);
    // Cycle 1: inputs scrambled so only latched fields can be used.
    req_valid[k] = 1'b0;
    req_func[k]  = 4'($urandom);
    req_addr[k]  = $urandom;
    req_wdata[k] = $urandom;
    check("c1.req_ready", 32'(req_ready[k]), 32'd0);
    if (e.err) begin
      check("err.mem_en", 32'(mem_en[k]), 32'd0);
      check("err.resp_valid", 32'(resp_valid[k]), 32'd1);
    end else begin
      check("c1.mem_en", 32'(mem_en[k]), 32'd1);
      check("c1.mem_wen", 32'(mem_wen[k]), 32'(e.wen));
      check("c1.mem_addr", mem_addr[k], {addr[31:2], 2'b00});
      check("c1.mem_wstrb", 32'(mem_wstrb[k]), 32'(e.wstrb));
      if (e.wen) check("c1.mem_wdata", mem_wdata[k], e.wdata);
      check("c1.resp_valid", 32'(resp_valid[k]), 32'd0);
      for (int c = 2; c <= 1 + lat; c++) begin
        @(negedge clk);
        mem_rdata[k] = (c == 1 + lat) ? word : $urandom;
        req_valid[k] = 1'($urandom);
        check("wait.mem_en", 32'(mem_en[k]), 32'd0);
        check("wait.mem_wstrb", 32'(mem_wstrb[k]), 32'd0);
        check("wait.resp_valid", 32'(resp_valid[k]), 32'd0);
      end
      @(negedge clk);
      mem_rdata[k] = $urandom;
      req_valid[k] = 1'b0;
      check("resp.resp_valid", 32'(resp_valid[k]), 32'd1);
      check("resp.mem_en", 32'(mem_en[k]), 32'd0);
    end
    check("resp.rdata", resp_rdata[k], e.rdata);
    check("resp.err", 32'(resp_err[k]), 32'(e.err));
    for (int h = 0; h < hold; h++) begin
      req_valid[k] = pulse ? 1'($urandom) : 1'b0;
      req_func[k]  = 4'd2;
      req_addr[k]  = 32'h80000000;
      @(negedge clk);
      check("hold.resp_valid", 32'(resp_valid[k]), 32'd1);
      check("hold.rdata", resp_rdata[k], e.rdata);
      check("hold.err", 32'(resp_err[k]), 32'(e.err));
      check("hold.req_ready", 32'(req_ready[k]), 32'd0);
      check("hold.mem_en", 32'(mem_en[k]), 32'd0);
    end
    req_valid[k]  = 1'b0;
    resp_ready[k] = 1'b1;
    @(negedge clk);
    resp_ready[k] = 1'b0;
    check("done.resp_valid", 32'(resp_valid[k]), 32'd0);
    check("done.req_ready", 32'(req_ready[k]), 32'd1);
    check("done.mem_en", 32'(mem_en[k]), 32'd0);
    $display("txn k=%0d func=%0d addr=%h wdata=%h word=%h hold=%0d -> err=%0d rdata=%h",
             k, func, addr, wdata, word, hold, e.err, e.rdata);
  endtask

  // Reset instance 1 asynchronously at cycle at_c of a load.
  task automatic rst_mid(input int at_c);
    req_valid[1] = 1'b1;
    req_func[1]  = 4'd2;
    req_addr[1]  = 32'h80000020;
    for (int c = 1; c <= at_c; c++) begin
      @(negedge clk);
      req_valid[1] = 1'b0;
    end
    #1 rst = 1'b1;
    #1 check_reset_vals(1, $sformatf("rstc%0d", at_c));
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < LAT1 + 3; c++) begin
      @(negedge clk);
      check("postrst.resp_valid", 32'(resp_valid[1]), 32'd0);
      check("postrst.mem_en", 32'(mem_en[1]), 32'd0);
    end
    $display("reset pulse at cycle %0d of in-flight load", at_c);
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 1'b0; req_addr[k] = 32'h0; req_func[k] = 4'h0;
      req_wdata[k] = 32'h0; resp_ready[k] = 1'b0; mem_rdata[k] = 32'h0;
    end
    repeat (2) @(negedge clk);
    check_reset_vals(0, "reset");
    check_reset_vals(1, "reset");
    rst = 1'b0;
    @(negedge clk);

    txn(0, 4'd2, 32'h80000004, 32'h0, 32'hDEADBEEF, 0, 0);
    txn(0, 4'd0, 32'h80000003, 32'h0, 32'h80112233, 1, 0);
    txn(0, 4'd3, 32'h80000003, 32'h0, 32'h80112233, 0, 0);
    txn(0, 4'd1, 32'h80000002, 32'h0, 32'h80112233, 0, 0);
    txn(0, 4'd4, 32'h80000002, 32'h0, 32'h80112233, 2, 1);
    txn(0, 4'd5, 32'h80000002, 32'h123456AB, 32'h55555555, 0, 0);
    txn(0, 4'd6, 32'h80000002, 32'h123456AB, 32'h55555555, 0, 0);
    txn(0, 4'd2, 32'h80000002, 32'h0, 32'h11111111, 0, 0);
    txn(0, 4'd6, 32'h80000001, 32'h0, 32'h11111111, 1, 1);
    txn(0, 4'd9, 32'h80000000, 32'h0, 32'h11111111, 0, 0);
    txn(1, 4'd2, 32'h80000010, 32'h0, 32'hCAFEF00D, 5, 1);

    for (int n = 0; n < 40; n++) begin
      txn(n % 2, 4'($urandom_range(0, 15)), $urandom, $urandom, $urandom,
          int'($urandom_range(0, 3)), 1'($urandom));
    end

    rst_mid(1);
    txn(1, 4'd4, 32'h80000006, 32'h0, 32'hF00DBEEF, 0, 0);
    rst_mid(3);
    txn(1, 4'd7, 32'h80000008, 32'hA5A5_5A5A, 32'h0, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ysyx_25030093_dmem_ctrl.md
# ysyx_25030093_dmem_ctrl

Multi-cycle data-memory controller sitting directly downstream of the LSU; it replaces the LSU's zero-time DPI memory calls with a timed request/response path. It accepts one load/store request at a time through a valid/ready handshake and drives a word-wide, byte-strobed SRAM port with fixed read latency. For loads it aligns and sign- or zero-extends the returned lane. Misaligned or illegal requests are reported as errors without touching memory.

## Interface
- LATENCY, 1: cycles from mem_en to valid mem_rdata; legal range 1..15.
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  LSU presents a request.
- req_ready  out  1  controller can accept; high only in IDLE.
- req_addr  in  32  byte address.
- req_func  in  4  0 lb, 1 lh, 2 lw, 3 lbu, 4 lhu, 5 sb, 6 sh, 7 sw; 8..15 illegal.
- req_wdata  in  32  store data, right-aligned (rs2).
- resp_valid  out  1  response available; held until accepted.
- resp_ready  in  1  consumer accepts response.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned or illegal request.
- mem_en  out  1  one-cycle memory access strobe.
- mem_wen  out  1  access is a write; qualified by mem_en.
- mem_addr  out  32  {req_addr[31:2], 2'b00}.
- mem_wstrb  out  4  byte write enables; 0000 for reads.
- mem_wdata  out  32  lane-replicated store data.
- mem_rdata  in  32  read word, valid LATENCY cycles after mem_en.

## Operation
- States: IDLE, ACCESS, WAIT, RESP. Request fields latched on req_valid && req_ready.
- IDLE -> ACCESS on legal accepted request; IDLE -> RESP with resp_err=1 on illegal/misaligned request (no mem_en).
- Misaligned: func 1/4/6 with addr[0]=1; func 2/7 with addr[1:0]!=0. Illegal: func 8..15.
- ACCESS: mem_en=1 exactly one cycle; 4-bit counter loaded with LATENCY; -> WAIT.
- WAIT: counter decrements each cycle; in the cycle it reads 1, mem_rdata is captured (loads) and state -> RESP. Stores wait identically.
- RESP: resp_valid=1; -> IDLE on resp_ready. resp_rdata/resp_err stable while resp_valid.
- Lanes: byte = word >> 8*addr[1:0]; half = word >> 16*addr[1]. lb/lh sign-extend bit 7/15; lbu/lhu zero-extend; lw passes word.
- Stores: sb wstrb = 0001 << addr[1:0], wdata = {4{wdata[7:0]}}; sh wstrb = 0011 << 2*addr[1], wdata = {2{wdata[15:0]}}; sw wstrb 1111, wdata as is.
- mem_* outputs driven from latched fields; mem_wen/mem_wstrb/mem_addr/mem_wdata are 0 outside ACCESS.

## Timing
- Reset values: state IDLE, req_ready 1, resp_valid 0, resp_rdata 0, resp_err 0, mem_en 0, mem_wen 0, mem_wstrb 0, mem_addr 0, mem_wdata 0, counter 0.
- Accept edge ends cycle 0; mem_en in cycle 1; mem_rdata sampled at end of cycle 1+LATENCY; resp_valid first high in cycle 2+LATENCY. Total latency LATENCY+2 cycles.
- Error path: resp_valid in cycle 1, no memory traffic.
- resp_ready high in the first RESP cycle: response completes that cycle; req_ready high next cycle (no same-cycle re-accept). Throughput: one request per LATENCY+3 cycles minimum.
- resp_ready low: RESP held indefinitely; req_ready stays 0; req_valid ignored.
- req_valid while not IDLE: ignored, no side effects.
- rst asserted mid-operation: immediate return to reset values; in-flight access abandoned, mem_en drops combinationally with reset, no response produced.

## Test plan
- LATENCY=1, lw addr 0x80000004, mem_rdata 0xDEADBEEF -> mem_en cycle 1 with mem_addr 0x80000004, wstrb 0000; resp_valid cycle 3, rdata 0xDEADBEEF, err 0.
- lb addr 0x80000003, word 0x80112233 -> rdata 0xFFFFFF80; lbu same -> 0x00000080; lh addr ...2 -> 0xFFFF8011; lhu -> 0x00008011.
- sb addr 0x80000002 wdata 0x123456AB -> mem_wen 1, wstrb 0100, wdata 0xABABABAB; sh addr ...2 -> wstrb 1100, wdata 0x56AB56AB; resp rdata 0.
- lw addr 0x80000002, sh addr 0x80000001, func 9 -> resp_err 1 in cycle 1, rdata 0, mem_en never asserted.
- LATENCY=4, resp_ready held low 5 cycles after resp_valid -> resp_valid appears cycle 6, stays stable; req_valid pulses meanwhile not accepted; completes on resp_ready.
- rst pulse during WAIT -> all outputs return to reset values asynchronously; next request after reset completes normally.
